// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// column drive reset value, the "clear entry" key code and a helper that
// returns the index of the lowest active-low bit of a 4-bit vector.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] KEY_CLEAR = 4'd14;

    // Lowest index whose bit is 0; callers only use it on vectors that have
    // at least one bit low (row patterns with a press, one-cold column drive).
    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick
// Free-running prescaler: counts 0..CLK_DIV-1 and wraps, producing a
// one-cycle scan tick while the count sits at CLK_DIV-1.
// Ports:
//   i_clk    - clock
//   i_resetn - asynchronous active-low reset (count cleared to 0)
//   o_tick   - one-cycle scan tick
module keypad_tick #(
    parameter int CLK_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_resetn,
    output logic o_tick
);

    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner with debounce, a valid/ready key event output,
// a sticky overflow flag and an optional four-digit BCD entry accumulator.
// Optional feature macro: KEYPAD_DIGIT_ACCUM_EN (enables the o_bcd accumulator;
// without it o_bcd is tied to 0).
// Ports:
//   i_clk      - clock, all logic on the rising edge
//   i_resetn   - asynchronous active-low reset
//   i_row      - keypad rows, active-low, asynchronous (synchronized here)
//   o_col      - column drive, active-low, one column low at a time
//   o_key      - key code = row_index*4 + col_index
//   o_valid    - key event pending on o_key
//   i_ready    - consumer accepts the event when high together with o_valid
//   o_overflow - sticky, set when an event is dropped
//   o_bcd      - four-digit entry, digit 0 in [3:0]
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SCAN     | rotating the column drive, looking for any low row
// ST_DEBOUNCE | column frozen, counting ticks with an unchanged row pattern
// ST_HELD     | event emitted, column frozen, counting all-high ticks
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [3:0]  o_key,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_overflow,
    output logic [15:0] o_bcd
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic             w_tick;
    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_col;
    logic [3:0]       w_col_nxt;
    logic [3:0]       r_pattern;
    logic [3:0]       w_pattern_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_any_low;
    logic [3:0]       w_col_rot;
    logic             w_event;
    logic [3:0]       w_event_key;
    logic [3:0]       r_key;
    logic             r_valid;
    logic             r_overflow;
    logic             w_accept;

    keypad_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .o_tick   (w_tick)
    );

    // Rows idle high, so the synchronizer resets to all-ones.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_any_low = ~&r_row_sync;
    assign w_col_rot = {r_col[2:0], r_col[3]};
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state   <= ST_SCAN;
            r_col     <= COL_RESET;
            r_pattern <= 4'hF;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_pattern <= w_pattern_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_pattern_nxt = r_pattern;
        w_cnt_nxt     = r_cnt;
        w_event       = 1'b0;
        w_event_key   = {first_low(r_pattern), first_low(r_col)};
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_any_low) begin
                        w_pattern_nxt = r_row_sync;
                        if (DEBOUNCE_SCANS == 1) begin
                            // Single-scan debounce: the detecting tick qualifies.
                            w_event     = 1'b1;
                            w_event_key = {first_low(r_row_sync), first_low(r_col)};
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end else begin
                        w_col_nxt = w_col_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_row_sync == r_pattern) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_event     = 1'b1;
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = w_col_rot;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_HELD: begin
                    if (!w_any_low) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_state_nxt = ST_SCAN;
                            w_col_nxt   = w_col_rot;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_SCAN;
                    w_col_nxt   = COL_RESET;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_accept = r_valid & i_ready;

    // A new event may replace the pending one only if that one is being
    // accepted in the same cycle; otherwise the new event is lost.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_key      <= 4'd0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_event) begin
            if (!r_valid || i_ready) begin
                r_key   <= w_event_key;
                r_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_col      = r_col;
    assign o_key      = r_key;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;

`ifdef KEYPAD_DIGIT_ACCUM_EN
    logic [15:0] r_bcd;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_bcd <= '0;
        end else if (w_accept) begin
            if (r_key <= 4'd9) begin
                r_bcd <= {r_bcd[11:0], r_key};
            end else if (r_key == KEY_CLEAR) begin
                r_bcd <= '0;
            end
        end
    end

    assign o_bcd = r_bcd;
`else
    assign o_bcd = '0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Bench for keypad_scan with CLK_DIV=4, DEBOUNCE_SCANS=2. A keypad matrix
// model turns a set of pressed keys into row levels from the column drive;
// a monitor records every accepted key code.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ready;
    logic [15:0] pressed;
    logic        use_matrix;
    logic [3:0]  row_drv;
    logic [3:0]  matrix_rows;
    logic [3:0]  row_in;
    logic [3:0]  o_col;
    logic [3:0]  o_key;
    logic        o_valid;
    logic        o_overflow;
    logic [15:0] o_bcd;

    int errors = 0;
    int checks = 0;
    logic [3:0] acc_q[$];

    always #5 clk = ~clk;

    keypad_scan #(
        .CLK_DIV        (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_row      (row_in),
        .o_col      (o_col),
        .o_key      (o_key),
        .o_valid    (o_valid),
        .i_ready    (ready),
        .o_overflow (o_overflow),
        .o_bcd      (o_bcd)
    );

    // Key at (r,c) is bit r*4+c of pressed; it pulls row r low while column c is driven low.
    always_comb begin
        matrix_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !o_col[c]) matrix_rows[r] = 1'b0;
    end
    assign row_in = use_matrix ? matrix_rows : row_drv;

    always @(posedge clk)
        if (resetn === 1'b1 && o_valid === 1'b1 && ready === 1'b1) acc_q.push_back(o_key);

    function automatic logic [3:0] col_drive(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return ~v;
    endfunction

    task automatic apply_reset;
        resetn = 1'b0; ready = 1'b1; pressed = '0; use_matrix = 1'b1; row_drv = 4'hF;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        acc_q.delete();
    endtask

    task automatic tap(input int code, input int hold, input int gap);
        pressed = 16'(1) << code;
        repeat (hold) @(negedge clk);
        pressed = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset;
        checks++; if (o_col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", o_col); end
        checks++; if (o_key !== 4'd0) begin errors++; $display("FAIL reset_key: got %0d want 0", o_key); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        checks++; if (o_bcd !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h want 0000", o_bcd); end
    endtask

    task automatic test_idle_rotation;
        logic [3:0] prev;
        int cnt;
        apply_reset;
        prev = o_col;
        for (int i = 0; i < 5; i++) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (o_col === prev && cnt < 12);
            checks++;
            if (o_col !== col_drive((i + 1) % 4) || cnt != 4) begin
                errors++;
                $display("FAIL idle_rot step %0d: got col %b after %0d cycles want col %b after 4", i, o_col, cnt, col_drive((i + 1) % 4));
            end
            prev = o_col;
        end
        checks++; if (o_valid !== 1'b0 || acc_q.size() != 0) begin errors++; $display("FAIL idle_valid: got valid %b events %0d want 0 0", o_valid, acc_q.size()); end
    endtask

    task automatic test_press_held;
        int cnt;
        int bad;
        apply_reset;
        pressed = 16'(1) << 9;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (o_valid !== 1'b1 && cnt < 100);
        checks++; if (o_valid !== 1'b1 || o_key !== 4'd9) begin errors++; $display("FAIL press_event: got valid %b key %0d want 1 9", o_valid, o_key); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL press_accept: got valid %b want 0", o_valid); end
        bad = 0;
        repeat (40) begin @(negedge clk); if (o_col !== 4'b1101) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_col_frozen: got %0d cycles off 1101 want 0", bad); end
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL held_no_repeat: got %0d events want 1", acc_q.size()); end
        pressed = '0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (o_col === 4'b1101 && cnt < 30);
        checks++;
        if (o_col !== 4'b1011 || cnt < 6 || cnt > 11) begin
            errors++;
            $display("FAIL release_resume: got col %b after %0d cycles want 1011 within 6..11", o_col, cnt);
        end
    endtask

    task automatic test_bounce;
        logic [3:0] prev;
        logic [3:0] c_now;
        int idx;
        int cnt;
        apply_reset;
        use_matrix = 1'b0;
        prev = o_col;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (o_col === prev && cnt < 12);
        c_now = o_col;
        idx = 0;
        for (int i = 0; i < 4; i++) if (c_now === col_drive(i)) idx = i;
        row_drv = 4'b1110;
        repeat (4) @(negedge clk);
        checks++; if (o_col !== c_now) begin errors++; $display("FAIL bounce_freeze: got %b want %b", o_col, c_now); end
        row_drv = 4'hF;
        repeat (4) @(negedge clk);
        checks++; if (o_col !== col_drive((idx + 1) % 4)) begin errors++; $display("FAIL bounce_advance: got %b want %b", o_col, col_drive((idx + 1) % 4)); end
        repeat (12) @(negedge clk);
        checks++; if (o_valid !== 1'b0 || acc_q.size() != 0) begin errors++; $display("FAIL bounce_no_event: got valid %b events %0d want 0 0", o_valid, acc_q.size()); end
        use_matrix = 1'b1;
    endtask

    task automatic test_overflow;
        apply_reset;
        ready = 1'b0;
        tap(5, 60, 40);
        tap(6, 60, 40);
        checks++; if (o_valid !== 1'b1 || o_key !== 4'd5) begin errors++; $display("FAIL ovf_hold: got valid %b key %0d want 1 5", o_valid, o_key); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovf_accept: got valid %b want 0", o_valid); end
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 4'd5) begin
            errors++;
            $display("FAIL ovf_accepted_code: got %0d events first %0d want 1 event code 5", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 4'd0);
        end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] prev;
        int cnt;
        bit found;
        apply_reset;
        ready = 1'b0;
        tap(5, 60, 40);
        acc_q.delete();
        prev = o_col;
        found = 0;
        cnt = 0;
        while (!found && cnt < 40) begin
            @(negedge clk); cnt++;
            if (o_col === 4'b1011 && prev !== 4'b1011) found = 1;
            prev = o_col;
        end
        checks++; if (!found) begin errors++; $display("FAIL b2b_align: got no col 1011 in %0d cycles want found", cnt); end
        pressed = 16'(1) << 6;
        repeat (7) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_key !== 4'd6) begin errors++; $display("FAIL b2b_new_event: got valid %b key %0d want 1 6", o_valid, o_key); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf: got %b want 0", o_overflow); end
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 4'd5) begin
            errors++;
            $display("FAIL b2b_accepted: got %0d events first %0d want 1 event code 5", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 4'd0);
        end
        pressed = '0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_accum;
        apply_reset;
`ifdef KEYPAD_DIGIT_ACCUM_EN
        tap(1, 60, 40); tap(2, 60, 40); tap(3, 60, 40); tap(4, 60, 40);
        checks++; if (o_bcd !== 16'h1234) begin errors++; $display("FAIL accum_digits: got %h want 1234", o_bcd); end
        tap(14, 60, 40);
        checks++; if (o_bcd !== 16'h0000) begin errors++; $display("FAIL accum_clear: got %h want 0000", o_bcd); end
        tap(7, 60, 40);
        checks++; if (o_bcd !== 16'h0007) begin errors++; $display("FAIL accum_after_clear: got %h want 0007", o_bcd); end
        tap(11, 60, 40);
        checks++; if (o_bcd !== 16'h0007) begin errors++; $display("FAIL accum_ignore: got %h want 0007", o_bcd); end
`else
        tap(1, 60, 40); tap(2, 60, 40);
        checks++; if (o_bcd !== 16'h0000) begin errors++; $display("FAIL accum_disabled: got %h want 0000", o_bcd); end
`endif
        checks++; if (acc_q.size() == 0) begin errors++; $display("FAIL accum_events: got 0 events want >0"); end
    endtask

    task automatic test_reset_mid_debounce;
        logic [3:0] prev;
        int cnt;
        bit found;
        apply_reset;
        ready = 1'b0;
        tap(5, 60, 40);
        prev = o_col;
        found = 0;
        cnt = 0;
        while (!found && cnt < 40) begin
            @(negedge clk); cnt++;
            if (o_col === 4'b1110 && prev !== 4'b1110) found = 1;
            prev = o_col;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_align: got no col 1110 in %0d cycles want found", cnt); end
        pressed = 16'(1) << 0;
        repeat (5) @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_key !== 4'd5) begin errors++; $display("FAIL rstmid_pending: got valid %b key %0d want 1 5", o_valid, o_key); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_key !== 4'd0 || o_overflow !== 1'b0 || o_col !== 4'b1110 || o_bcd !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid %b key %0d ovf %b col %b bcd %h want 0 0 0 1110 0000", o_valid, o_key, o_overflow, o_col, o_bcd);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (o_valid !== 1'b1 && cnt < 40);
        checks++; if (o_valid !== 1'b1 || o_key !== 4'd0 || cnt != 8) begin errors++; $display("FAIL rstmid_redebounce: got valid %b key %0d at cycle %0d want 1 0 at 8", o_valid, o_key, cnt); end
        ready = 1'b1;
        pressed = '0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_random;
        apply_reset;
        for (int it = 0; it < 12; it++) begin
            int c;
            int lo;
            int hold;
            logic [3:0] m;
            logic [3:0] exp_code;
            c = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            lo = 0;
            pressed = '0;
            for (int r = 3; r >= 0; r--) if (m[r]) begin pressed[r*4+c] = 1'b1; lo = r; end
            exp_code = 4'(lo * 4 + c);
            acc_q.delete();
            hold = $urandom_range(40, 70);
            repeat (hold) begin @(negedge clk); ready = 1'($urandom_range(0, 1)); end
            pressed = '0;
            repeat (40) begin @(negedge clk); ready = 1'($urandom_range(0, 1)); end
            ready = 1'b1;
            repeat (3) @(negedge clk);
            checks++;
            if (acc_q.size() != 1 || acc_q[0] !== exp_code) begin
                errors++;
                $display("FAIL rand_event it %0d: got %0d events first %0d want 1 event code %0d", it, acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 4'd0, exp_code);
            end
        end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf: got %b want 0", o_overflow); end
    endtask

    initial begin
        resetn = 1'b0; ready = 1'b1; pressed = '0; use_matrix = 1'b1; row_drv = 4'hF;
        test_reset;
        test_idle_rotation;
        test_press_held;
        test_bounce;
        test_overflow;
        test_back_to_back;
        test_accum;
        test_reset_mid_debounce;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 100000, giving i_clk cycles per scan tick (1 kHz at 100 MHz).
REQ-002 The module SHALL have parameter DEBOUNCE_SCANS, default 4, giving consecutive stable ticks required for press and release.
REQ-003 The module SHALL have port i_clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port i_resetn, input, 1, reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_row, input, 4, keypad rows, active-low, externally pulled up and asynchronous to i_clk.
REQ-006 The module SHALL have port o_col, output, 4, keypad column drive, active-low, one bit low at a time.
REQ-007 The module SHALL have port o_key, output, 4, key code equal to row_index*4 + col_index.
REQ-008 The module SHALL have port o_valid, output, 1, asserted while an unaccepted key event is present on o_key.
REQ-009 The module SHALL have port i_ready, input, 1, consumer accepts the event when i_ready and o_valid are high in the same cycle.
REQ-010 The module SHALL have port o_overflow, output, 1, sticky flag set when a key event is dropped.
REQ-011 The module SHALL have port o_bcd, output, 16, four-digit entry value in the same nibble order as the display driver input (digit 0 in [3:0]).

Function
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 and wrap, with a one-cycle tick when count equals CLK_DIV-1.
REQ-013 i_row SHALL pass through a 2-flop synchronizer; all row decisions SHALL use the synchronized value.
REQ-014 The FSM SHALL have states SCAN, DEBOUNCE and HELD, and SHALL evaluate only on tick cycles.
REQ-015 In SCAN, on a tick with no row low, o_col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-016 In SCAN, on a tick with any row low, the FSM SHALL capture the row pattern, keep o_col frozen, set the stable count to 1, and go to DEBOUNCE.
REQ-017 In DEBOUNCE, a tick with an identical pattern SHALL increment the count; on reaching DEBOUNCE_SCANS the FSM SHALL emit an event and go to HELD.
REQ-018 In DEBOUNCE, a tick with a different pattern or all rows high SHALL return the FSM to SCAN and advance o_col, with no event.
REQ-019 When multiple rows are low, the lowest-index row SHALL define o_key.
REQ-020 In HELD, o_col SHALL stay frozen; DEBOUNCE_SCANS consecutive all-high ticks SHALL return the FSM to SCAN and advance o_col, and any low row SHALL reset the release count to 0.
REQ-021 An event SHALL load o_key and set o_valid on the cycle after the qualifying tick.
REQ-022 o_valid SHALL remain high, with o_key stable, until accepted.
REQ-023 An event arriving while o_valid is high and i_ready is low SHALL be dropped and SHALL set o_overflow.
REQ-024 An acceptance in the same cycle as a new event SHALL load the new event with no overflow.
REQ-025 With DEBOUNCE_SCANS=1, a press SHALL emit on the first tick that detects it, going directly from SCAN to HELD.

Reset
REQ-026 Assertion of i_resetn low SHALL immediately force: o_col=1110, o_key=0, o_valid=0, o_overflow=0, o_bcd=0, FSM=SCAN, prescaler=0, all counters and synchronizers cleared (rows read as high).
REQ-027 Reset mid-debounce or mid-hold SHALL discard the pending key with no event after release.

Configuration
REQ-028 Macro KEYPAD_DIGIT_ACCUM_EN SHALL control the digit accumulator.
REQ-029 With KEYPAD_DIGIT_ACCUM_EN defined, each accepted event SHALL update o_bcd: code 0..9 gives {o_bcd[11:0], code}; code 14 clears o_bcd to 0; other codes leave it unchanged.
REQ-030 Without KEYPAD_DIGIT_ACCUM_EN, o_bcd SHALL be constant 0 and no accumulator registers SHALL exist.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum, COL_RESET (4'b1110) and KEY_CLEAR (4'd14).
REQ-032 The prescaler SHALL be a sub-module, keypad_tick, with parameter CLK_DIV and a 1-bit tick output.

Verification (CLK_DIV=4, DEBOUNCE_SCANS=2)
REQ-033 Idle rows 1111 -> o_col rotates every 4 cycles through 1110, 1101, 1011, 0111, 1110; o_valid stays 0.
REQ-034 i_row=1011 while o_col=1101 for 3+ ticks, i_ready=1 -> one o_valid pulse with o_key=9; no repeat while held; scanning resumes 2 ticks after release.
REQ-035 Row low for 1 tick only (bounce) -> no event; o_col advances.
REQ-036 i_ready=0, two separate presses (codes 5 then 6) -> o_key=5 held, o_overflow=1; then i_ready=1 -> code 5 accepted, o_valid=0.
REQ-037 With accumulator enabled, accept codes 1, 2, 3, 4 -> o_bcd=16'h1234; then code 14 -> o_bcd=0; code 11 -> o_bcd unchanged.
REQ-038 i_resetn low during DEBOUNCE -> outputs equal reset values the same cycle; key held through reset release yields no event until re-debounced in SCAN.
